// File: rtl/fmv_pkg.sv
// Shared types and default constants for the FMV frame queue: slot life-cycle
// states, the planar YUV frame descriptor and the slot address helper.
package fmv_pkg;

  localparam logic [28:0] DEF_SLOT_BASE     = 29'h0040_0000;
  localparam logic [28:0] DEF_SLOT_STRIDE   = 29'h0003_0000;
  localparam logic [28:0] DEF_Y_PLANE_BYTES = 29'h0002_0000;
  localparam logic [28:0] DEF_C_PLANE_BYTES = 29'h0000_8000;

  typedef enum logic [2:0] {
    SLOT_FREE,
    SLOT_DECODING,
    SLOT_READY,
    SLOT_SHOWN,
    SLOT_RETIRING
  } slot_state_e;

  // Byte addresses of the three planes of one frame buffer, shared with the player.
  typedef struct packed {
    logic [28:0] y;
    logic [28:0] u;
    logic [28:0] v;
  } planar_yuv_s;

  // Plane addresses of slot k; 29-bit arithmetic wraps silently.
  function automatic planar_yuv_s slot_frame(input logic [2:0]  k,
                                             input logic [28:0] base,
                                             input logic [28:0] stride,
                                             input logic [28:0] y_bytes,
                                             input logic [28:0] c_bytes);
    planar_yuv_s f;
    f.y = base + 29'(k) * stride;
    f.u = f.y + y_bytes;
    f.v = f.u + c_bytes;
    return f;
  endfunction

endpackage

// File: rtl/fmv_slot_fifo.sv
// In-order queue of committed frames {slot, width, height}. The caller never
// pops when empty and never pushes when full; a push in the clear cycle survives.
module fmv_slot_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 20
) (
  input  logic                       clkddr,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  input  logic                       clear,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clkddr) begin
    if (push) mem[clear ? '0 : wr_ptr] <= din;
  end

  always_ff @(posedge clkddr or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= push ? AW'(1) : '0;
      count  <= push ? CW'(1) : '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fmv_frame_queue.sv
// Frame buffer pool between the MPEG decoder and the FMV frame player.
// Optional FMV_FRAME_REPEAT_EN adds repeat_count to hold each frame for N+1 vsyncs.
module fmv_frame_queue
  import fmv_pkg::*;
#(
  parameter int          NUM_SLOTS     = 4,
  parameter logic [28:0] SLOT_BASE     = DEF_SLOT_BASE,
  parameter logic [28:0] SLOT_STRIDE   = DEF_SLOT_STRIDE,
  parameter logic [28:0] Y_PLANE_BYTES = DEF_Y_PLANE_BYTES,
  parameter logic [28:0] C_PLANE_BYTES = DEF_C_PLANE_BYTES
) (
  input  logic                          clkddr,
  input  logic                          reset_n,
  input  logic                          alloc_req,
  output logic                          alloc_ack,
  output logic [$clog2(NUM_SLOTS)-1:0]  alloc_slot,
  output planar_yuv_s                   alloc_frame,
  input  logic                          commit,
  input  logic [$clog2(NUM_SLOTS)-1:0]  commit_slot,
  input  logic [8:0]                    commit_width,
  input  logic [8:0]                    commit_height,
  input  logic                          discard,
  input  logic                          flush,
  input  logic                          stop,
  input  logic                          vsync_pulse,
`ifdef FMV_FRAME_REPEAT_EN
  input  logic [1:0]                    repeat_count,
`endif
  output planar_yuv_s                   frame,
  output logic [8:0]                    frame_width,
  output logic [8:0]                    frame_height,
  output logic                          latch_frame,
  output logic                          invalidate,
  output logic [3:0]                    free_count,
  output logic [3:0]                    ready_count,
  output logic                          protocol_error
);

  localparam int SW = $clog2(NUM_SLOTS);
  localparam int EW = SW + 18;
  localparam int CW = SW + 1;

  slot_state_e   state   [NUM_SLOTS];
  slot_state_e   state_n [NUM_SLOTS];

  logic [EW-1:0] head;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [SW-1:0] head_slot;
  logic [8:0]    head_width;
  logic [8:0]    head_height;
  logic          hold_ok;
  logic          do_pop;
  logic          do_push;
  logic          grant;
  logic [SW-1:0] grant_slot;
  logic          err_set;
  logic [3:0]    free_n;

  assign {head_slot, head_width, head_height} = head;
  assign fifo_empty  = (fifo_count == '0);
  // The FIFO holds exactly the READY slots, so its count is the ready count.
  assign ready_count = 4'(fifo_count);

  fmv_slot_fifo #(
    .DEPTH (NUM_SLOTS),
    .W     (EW)
  ) u_fifo (
    .clkddr  (clkddr),
    .reset_n (reset_n),
    .push    (do_push),
    .din     ({commit_slot, commit_width, commit_height}),
    .pop     (do_pop),
    .clear   (flush),
    .dout    (head),
    .count   (fifo_count)
  );

`ifdef FMV_FRAME_REPEAT_EN
  logic [1:0] hold_cnt;

  always_ff @(posedge clkddr or negedge reset_n) begin
    if (!reset_n)                          hold_cnt <= '0;
    else if (stop)                         hold_cnt <= '0;
    else if (do_pop)                       hold_cnt <= repeat_count;
    else if (vsync_pulse && hold_cnt != 0) hold_cnt <= hold_cnt - 2'd1;
  end

  assign hold_ok = (hold_cnt == 2'd0);
`else
  assign hold_ok = 1'b1;
`endif

  // All decisions look at pre-cycle state, so a slot freed now is grantable next cycle.
  always_comb begin
    state_n    = state;
    err_set    = 1'b0;
    do_push    = 1'b0;
    grant      = 1'b0;
    grant_slot = '0;
    free_n     = '0;
    do_pop     = vsync_pulse && !stop && !flush && !fifo_empty && hold_ok;

    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (stop && (state[k] == SLOT_SHOWN || state[k] == SLOT_RETIRING))
        state_n[k] = SLOT_FREE;
      else if (vsync_pulse && state[k] == SLOT_RETIRING)
        state_n[k] = SLOT_FREE;
      else if (do_pop && state[k] == SLOT_SHOWN)
        state_n[k] = SLOT_RETIRING;
      else if (flush && state[k] == SLOT_READY)
        state_n[k] = SLOT_FREE;
    end

    if (do_pop) state_n[head_slot] = SLOT_SHOWN;

    if (commit) begin
      if (state[commit_slot] == SLOT_DECODING) begin
        state_n[commit_slot] = SLOT_READY;
        do_push              = 1'b1;
      end else begin
        err_set = 1'b1;
      end
    end

    if (discard) begin
      if (state[commit_slot] == SLOT_DECODING) state_n[commit_slot] = SLOT_FREE;
      else                                     err_set = 1'b1;
    end

    if (alloc_req && !alloc_ack) begin
      for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
        if (state[k] == SLOT_FREE) begin
          grant      = 1'b1;
          grant_slot = SW'(k);
        end
      end
    end
    if (grant) state_n[grant_slot] = SLOT_DECODING;

    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (state_n[k] == SLOT_FREE) free_n = free_n + 4'd1;
    end
  end

  always_ff @(posedge clkddr or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_SLOTS; k++) state[k] <= SLOT_FREE;
      alloc_ack      <= 1'b0;
      alloc_slot     <= '0;
      alloc_frame    <= '0;
      frame          <= '0;
      frame_width    <= '0;
      frame_height   <= '0;
      latch_frame    <= 1'b0;
      invalidate     <= 1'b0;
      free_count     <= 4'(NUM_SLOTS);
      protocol_error <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_SLOTS; k++) state[k] <= state_n[k];
      alloc_ack   <= grant;
      latch_frame <= do_pop;
      invalidate  <= stop;
      free_count  <= free_n;
      if (grant) begin
        alloc_slot  <= grant_slot;
        alloc_frame <= slot_frame(3'(grant_slot), SLOT_BASE, SLOT_STRIDE,
                                  Y_PLANE_BYTES, C_PLANE_BYTES);
      end
      if (do_pop) begin
        frame        <= slot_frame(3'(head_slot), SLOT_BASE, SLOT_STRIDE,
                                   Y_PLANE_BYTES, C_PLANE_BYTES);
        frame_width  <= head_width;
        frame_height <= head_height;
      end
      if (err_set) protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fmv_frame_queue.sv
// Directed bench for fmv_frame_queue: allocation, in-order presentation,
// simultaneous events, flush, stop and (with FMV_FRAME_REPEAT_EN) frame repeat.
module tb_fmv_frame_queue;
  import fmv_pkg::*;

  logic        clkddr = 1'b0;
  logic        reset_n;
  logic        alloc_req;
  logic        alloc_ack;
  logic [1:0]  alloc_slot;
  planar_yuv_s alloc_frame;
  logic        commit;
  logic [1:0]  commit_slot;
  logic [8:0]  commit_width;
  logic [8:0]  commit_height;
  logic        discard;
  logic        flush;
  logic        stop;
  logic        vsync_pulse;
`ifdef FMV_FRAME_REPEAT_EN
  logic [1:0]  repeat_count;
`endif
  planar_yuv_s frame;
  logic [8:0]  frame_width;
  logic [8:0]  frame_height;
  logic        latch_frame;
  logic        invalidate;
  logic [3:0]  free_count;
  logic [3:0]  ready_count;
  logic        protocol_error;

  int n_assert = 0;
  int n_fail   = 0;

  fmv_frame_queue dut (
    .clkddr         (clkddr),
    .reset_n        (reset_n),
    .alloc_req      (alloc_req),
    .alloc_ack      (alloc_ack),
    .alloc_slot     (alloc_slot),
    .alloc_frame    (alloc_frame),
    .commit         (commit),
    .commit_slot    (commit_slot),
    .commit_width   (commit_width),
    .commit_height  (commit_height),
    .discard        (discard),
    .flush          (flush),
    .stop           (stop),
    .vsync_pulse    (vsync_pulse),
`ifdef FMV_FRAME_REPEAT_EN
    .repeat_count   (repeat_count),
`endif
    .frame          (frame),
    .frame_width    (frame_width),
    .frame_height   (frame_height),
    .latch_frame    (latch_frame),
    .invalidate     (invalidate),
    .free_count     (free_count),
    .ready_count    (ready_count),
    .protocol_error (protocol_error)
  );

  always #5 clkddr = ~clkddr;

  task automatic tick();
    @(posedge clkddr);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request a slot and wait (bounded) for the grant.
  task automatic do_alloc(input logic [1:0] exp_slot);
    alloc_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (alloc_ack) break;
    end
    check("alloc_ack", 32'(alloc_ack), 32'd1);
    check("alloc_slot", 32'(alloc_slot), 32'(exp_slot));
    alloc_req = 1'b0;
  endtask

  task automatic do_commit(input logic [1:0] s, input logic [8:0] w, input logic [8:0] h);
    commit = 1'b1; commit_slot = s; commit_width = w; commit_height = h;
    tick();
    commit = 1'b0;
  endtask

  task automatic do_vsync();
    vsync_pulse = 1'b1;
    tick();
    vsync_pulse = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; alloc_req = 1'b0; commit = 1'b0; commit_slot = '0;
    commit_width = '0; commit_height = '0; discard = 1'b0; flush = 1'b0;
    stop = 1'b0; vsync_pulse = 1'b0;
`ifdef FMV_FRAME_REPEAT_EN
    repeat_count = 2'd0;
`endif
    tick(); tick();
    check("rst_free_count", 32'(free_count), 32'd4);
    check("rst_ready_count", 32'(ready_count), 32'd0);
    check("rst_alloc_ack", 32'(alloc_ack), 32'd0);
    check("rst_latch", 32'(latch_frame), 32'd0);
    check("rst_perr", 32'(protocol_error), 32'd0);
    check("rst_frame_y", 32'(frame.y), 32'd0);
    reset_n = 1'b1;
    tick();

    // Allocation order and slot addresses
    do_alloc(2'd0);
    check("alloc0_y", 32'(alloc_frame.y), 32'h0040_0000);
    check("alloc0_u", 32'(alloc_frame.u), 32'h0042_0000);
    check("alloc0_v", 32'(alloc_frame.v), 32'h0042_8000);
    check("free_after_a0", 32'(free_count), 32'd3);
    do_alloc(2'd1);
    check("alloc1_y", 32'(alloc_frame.y), 32'h0043_0000);
    check("free_after_a1", 32'(free_count), 32'd2);
    do_alloc(2'd2);
    check("alloc2_y", 32'(alloc_frame.y), 32'h0046_0000);
    do_alloc(2'd3);
    check("alloc3_y", 32'(alloc_frame.y), 32'h0049_0000);
    check("free_after_a3", 32'(free_count), 32'd0);

    // Fifth request stalls while the pool is empty and stays held
    alloc_req = 1'b1;
    tick(); tick();
    check("stall_ack", 32'(alloc_ack), 32'd0);
    do_commit(2'd0, 9'd352, 9'd240);
    check("ready_after_c0", 32'(ready_count), 32'd1);
    do_vsync();
    check("v1_latch", 32'(latch_frame), 32'd1);
    check("v1_frame_y", 32'(frame.y), 32'h0040_0000);
    check("v1_width", 32'(frame_width), 32'd352);
    check("v1_height", 32'(frame_height), 32'd240);
    check("v1_ready", 32'(ready_count), 32'd0);
    do_vsync();
    check("v2_no_latch", 32'(latch_frame), 32'd0);
    check("v2_width_hold", 32'(frame_width), 32'd352);
    do_commit(2'd1, 9'd320, 9'd240);
    do_vsync();
    check("v3_latch", 32'(latch_frame), 32'd1);
    check("v3_frame_y", 32'(frame.y), 32'h0043_0000);
    check("v3_free", 32'(free_count), 32'd0);
    do_vsync();
    check("v4_free", 32'(free_count), 32'd1);
    check("v4_ack_not_yet", 32'(alloc_ack), 32'd0);
    tick();
    check("held_req_ack", 32'(alloc_ack), 32'd1);
    check("held_req_slot", 32'(alloc_slot), 32'd0);
    check("held_req_free", 32'(free_count), 32'd0);
    alloc_req = 1'b0;

    // Presentation follows commit order, not slot order
    do_commit(2'd3, 9'd176, 9'd144);
    do_commit(2'd2, 9'd320, 9'd200);
    check("ready_two", 32'(ready_count), 32'd2);
    do_vsync();
    check("v5_latch", 32'(latch_frame), 32'd1);
    check("v5_frame_y", 32'(frame.y), 32'h0049_0000);
    check("v5_width", 32'(frame_width), 32'd176);
    check("v5_height", 32'(frame_height), 32'd144);
    do_vsync();
    check("v6_latch", 32'(latch_frame), 32'd1);
    check("v6_frame_y", 32'(frame.y), 32'h0046_0000);
    check("v6_width", 32'(frame_width), 32'd320);
    check("v6_free", 32'(free_count), 32'd1);
    do_vsync();
    check("v7_no_latch", 32'(latch_frame), 32'd0);
    check("v7_free", 32'(free_count), 32'd2);

    // Commit and vsync together on an empty queue
    commit = 1'b1; commit_slot = 2'd0; commit_width = 9'd160; commit_height = 9'd120;
    vsync_pulse = 1'b1;
    tick();
    commit = 1'b0; vsync_pulse = 1'b0;
    check("cv_no_latch", 32'(latch_frame), 32'd0);
    check("cv_ready", 32'(ready_count), 32'd1);
    do_vsync();
    check("cv_next_latch", 32'(latch_frame), 32'd1);
    check("cv_frame_y", 32'(frame.y), 32'h0040_0000);
    check("cv_height", 32'(frame_height), 32'd120);

    // Flush with two READY frames, then protocol error and discard
    do_alloc(2'd1);
    do_alloc(2'd3);
    check("pre_flush_free", 32'(free_count), 32'd0);
    do_commit(2'd1, 9'd64, 9'd48);
    do_commit(2'd3, 9'd64, 9'd48);
    check("pre_flush_ready", 32'(ready_count), 32'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ready", 32'(ready_count), 32'd0);
    check("flush_free", 32'(free_count), 32'd2);
    check("flush_perr", 32'(protocol_error), 32'd0);
    do_commit(2'd1, 9'd64, 9'd48);
    check("commit_free_perr", 32'(protocol_error), 32'd1);
    check("commit_free_ready", 32'(ready_count), 32'd0);
    do_alloc(2'd1);
    check("pre_discard_free", 32'(free_count), 32'd1);
    discard = 1'b1; commit_slot = 2'd1;
    tick();
    discard = 1'b0;
    check("discard_free", 32'(free_count), 32'd2);

    // Retire the old frame, then stop with one frame SHOWN
    do_vsync();
    check("retire_free", 32'(free_count), 32'd3);
    check("retire_no_latch", 32'(latch_frame), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_invalidate", 32'(invalidate), 32'd1);
    check("stop_free", 32'(free_count), 32'd4);
    check("stop_frame_hold", 32'(frame.y), 32'h0040_0000);
    check("stop_width_hold", 32'(frame_width), 32'd160);
    tick();
    check("invalidate_pulse", 32'(invalidate), 32'd0);

    // Stop beats vsync in the same cycle
    do_alloc(2'd0);
    do_commit(2'd0, 9'd100, 9'd50);
    stop = 1'b1; vsync_pulse = 1'b1;
    tick();
    stop = 1'b0; vsync_pulse = 1'b0;
    check("sv_no_latch", 32'(latch_frame), 32'd0);
    check("sv_ready", 32'(ready_count), 32'd1);
    check("sv_invalidate", 32'(invalidate), 32'd1);
    do_vsync();
    check("sv_next_latch", 32'(latch_frame), 32'd1);
    check("sv_width", 32'(frame_width), 32'd100);

`ifdef FMV_FRAME_REPEAT_EN
    // Each frame held for two vsyncs
    repeat_count = 2'd1;
    do_alloc(2'd1);
    do_alloc(2'd2);
    do_commit(2'd1, 9'd11, 9'd10);
    do_commit(2'd2, 9'd22, 9'd20);
    do_vsync();
    check("rep_a_latch", 32'(latch_frame), 32'd1);
    check("rep_a_width", 32'(frame_width), 32'd11);
    do_vsync();
    check("rep_b_no_latch", 32'(latch_frame), 32'd0);
    do_vsync();
    check("rep_c_latch", 32'(latch_frame), 32'd1);
    check("rep_c_width", 32'(frame_width), 32'd22);
`endif

    // Asynchronous reset mid-operation
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_free", 32'(free_count), 32'd4);
    check("arst_ready", 32'(ready_count), 32'd0);
    check("arst_perr", 32'(protocol_error), 32'd0);
    check("arst_frame_y", 32'(frame.y), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
